// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and byte-lane helpers for the memory-access stage.
package mem_access_ctrl_pkg;

    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned ADDR_W     = 15;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAcc1  = 3'd1,
        StAcc2  = 3'd2,
        StDone  = 3'd3,
        StDrain = 3'd4
    } state_e;

    // Size3B only appears on the cache port for a three-byte spill part.
    typedef enum logic [1:0] {
        Size1B = 2'd0,
        Size2B = 2'd1,
        Size4B = 2'd2,
        Size3B = 2'd3
    } req_size_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            Size1B:  return 3'd1;
            Size2B:  return 3'd2;
            Size3B:  return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] bytes_size(input logic [2:0] n);
        case (n)
            3'd1:    return Size1B;
            3'd2:    return Size2B;
            3'd3:    return Size3B;
            default: return Size4B;
        endcase
    endfunction

    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'h0000_00ff;
            3'd2:    return 32'h0000_ffff;
            3'd3:    return 32'h00ff_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_merge.sv
// Combines the two parts of a line-crossing load and clears lanes above the access size.
module mem_merge
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] first,
    input  logic [31:0] second,
    input  logic [2:0]  n1,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    logic [5:0] shamt;

    // n1 == 4 shifts the second part out entirely, giving a plain masked load.
    always_comb begin
        shamt  = {n1, 3'b000};
        merged = ((first & byte_mask(n1)) | (second << shamt)) & byte_mask(size_bytes(size));
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access stage: issues one or two cache transfers per load/store and returns the result.
// Line-crossing (spill) support is built only when MEM_SPLIT_EN is defined.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter bit SPLIT_EN_DEFAULT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_v,
    input  logic              i_rd,
    input  logic              i_wr,
    input  logic              i_cachable,
    input  logic [ADDR_W-1:0] i_phys_addr,
    input  logic [1:0]        i_reqSize,
    input  logic              i_spill,
    input  logic [31:0]       i_wdata,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic              dc_req,
    output logic              dc_we,
    output logic              dc_uc,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [1:0]        dc_size,
    output logic [31:0]       dc_wdata,
    input  logic              dc_ready,
    input  logic [31:0]       dc_rdata,
    output logic              o_stall,
    output logic              o_v,
    output logic [31:0]       o_rdata,
    output logic              o_align_fault
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uc_q, uc_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic              accept;
    logic              split_en;
    logic [31:0]       m_first, m_second, merged;
    logic [2:0]        m_n1;

`ifdef MEM_SPLIT_EN
    logic              split_en_q;
    logic              spill_q, spill_d;
    logic              phase2_q, phase2_d;
    logic [31:0]       first_q, first_d;
    logic [2:0]        n1, rem;
    logic [ADDR_W-1:0] line_addr;
    logic              sel_second;

    assign split_en = split_en_q;

    // phase2_q remembers which part a drain is finishing.
    always_comb begin
        n1         = 3'(LINE_BYTES - 32'(addr_q[3:0]));
        rem        = size_bytes(size_q) - n1;
        line_addr  = {addr_q[ADDR_W-1:4] + (ADDR_W-4)'(1), 4'h0};
        sel_second = (state_q == StAcc2) || ((state_q == StDrain) && phase2_q);
        m_first    = sel_second ? first_q : dc_rdata;
        m_second   = sel_second ? dc_rdata : 32'h0;
        m_n1       = sel_second ? n1 : 3'd4;
    end
`else
    // No split hardware in this build: every spill op faults.
    assign split_en = 1'b0 & SPLIT_EN_DEFAULT;

    always_comb begin
        m_first  = dc_rdata;
        m_second = 32'h0;
        m_n1     = 3'd4;
    end
`endif

    mem_merge u_merge (
        .first  (m_first),
        .second (m_second),
        .n1     (m_n1),
        .size   (size_q),
        .merged (merged)
    );

    always_comb begin
        dc_we    = we_q;
        dc_uc    = uc_q;
        dc_addr  = addr_q;
        dc_size  = size_q;
        dc_wdata = wdata_q & byte_mask(size_bytes(size_q));
`ifdef MEM_SPLIT_EN
        if (sel_second) begin
            dc_addr  = line_addr;
            dc_size  = bytes_size(rem);
            dc_wdata = (wdata_q >> {n1, 3'b000}) & byte_mask(rem);
        end else if (spill_q) begin
            dc_size  = bytes_size(n1);
            dc_wdata = wdata_q & byte_mask(n1);
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        we_d          = we_q;
        uc_d          = uc_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        accept        = 1'b0;
        dc_req        = 1'b0;
        o_v           = 1'b0;
        o_stall       = 1'b0;
        o_align_fault = 1'b0;
`ifdef MEM_SPLIT_EN
        spill_d       = spill_q;
        phase2_d      = phase2_q;
        first_d       = first_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Passthrough is suppressed while reset is held.
                if (rst) begin
                    if (i_v && (i_rd || i_wr) && !i_flush) begin
                        accept  = 1'b1;
                        o_stall = 1'b1;
                        state_d = (i_spill && !split_en) ? StDone : StAcc1;
                    end else begin
                        o_v     = i_v && !i_rd && !i_wr && !i_flush;
                        o_stall = i_stall;
                    end
                end
            end
            StAcc1: begin
                dc_req  = 1'b1;
                o_stall = 1'b1;
                if (dc_ready) begin
`ifdef MEM_SPLIT_EN
                    if (spill_q) begin
                        first_d = dc_rdata;
                    end else if (!we_q) begin
                        rdata_d = merged;
                    end
                    if (i_flush) begin
                        state_d = StIdle;
                    end else if (spill_q) begin
                        state_d  = StAcc2;
                        phase2_d = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
`else
                    if (!we_q) begin
                        rdata_d = merged;
                    end
                    state_d = i_flush ? StIdle : StDone;
`endif
                end else if (i_flush) begin
                    state_d = StDrain;
                end
            end
`ifdef MEM_SPLIT_EN
            StAcc2: begin
                dc_req  = 1'b1;
                o_stall = 1'b1;
                if (dc_ready) begin
                    if (!we_q) begin
                        rdata_d = merged;
                    end
                    state_d = i_flush ? StIdle : StDone;
                end else if (i_flush) begin
                    state_d = StDrain;
                end
            end
`endif
            StDone: begin
                o_v           = 1'b1;
                o_stall       = i_stall;
                o_align_fault = fault_q;
                if (i_flush || !i_stall) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                dc_req  = 1'b1;
                o_stall = 1'b1;
                if (dc_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            addr_d  = i_phys_addr;
            size_d  = i_reqSize;
            we_d    = i_wr;
            uc_d    = ~i_cachable;
            wdata_d = i_wdata;
            rdata_d = 32'h0;
            fault_d = i_spill && !split_en;
`ifdef MEM_SPLIT_EN
            spill_d  = i_spill;
            phase2_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uc_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uc_q    <= uc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

`ifdef MEM_SPLIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            split_en_q <= SPLIT_EN_DEFAULT;
            spill_q    <= 1'b0;
            phase2_q   <= 1'b0;
            first_q    <= '0;
        end else begin
            split_en_q <= split_en_q;
            spill_q    <= spill_d;
            phase2_q   <= phase2_d;
            first_q    <= first_d;
        end
    end
`endif

    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; spill vectors follow the MEM_SPLIT_EN build.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_v, i_rd, i_wr, i_cachable, i_spill, i_stall, i_flush;
    logic [14:0] i_phys_addr;
    logic [1:0]  i_reqSize;
    logic [31:0] i_wdata;
    logic        dc_req, dc_we, dc_uc, dc_ready;
    logic [14:0] dc_addr;
    logic [1:0]  dc_size;
    logic [31:0] dc_wdata, dc_rdata;
    logic        o_stall, o_v, o_align_fault;
    logic [31:0] o_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .i_v           (i_v),
        .i_rd          (i_rd),
        .i_wr          (i_wr),
        .i_cachable    (i_cachable),
        .i_phys_addr   (i_phys_addr),
        .i_reqSize     (i_reqSize),
        .i_spill       (i_spill),
        .i_wdata       (i_wdata),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .dc_uc         (dc_uc),
        .dc_addr       (dc_addr),
        .dc_size       (dc_size),
        .dc_wdata      (dc_wdata),
        .dc_ready      (dc_ready),
        .dc_rdata      (dc_rdata),
        .o_stall       (o_stall),
        .o_v           (o_v),
        .o_rdata       (o_rdata),
        .o_align_fault (o_align_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [14:0] addr,
                           input logic [1:0] sz, input logic spill, input logic cach,
                           input logic [31:0] wd);
        i_v         = 1'b1;
        i_rd        = rd;
        i_wr        = wr;
        i_phys_addr = addr;
        i_reqSize   = sz;
        i_spill     = spill;
        i_cachable  = cach;
        i_wdata     = wd;
    endtask

    // Garbage on the latch side checks that the captured request stays put.
    task automatic clear_op();
        i_v         = 1'b0;
        i_rd        = 1'b0;
        i_wr        = 1'b0;
        i_spill     = 1'b0;
        i_phys_addr = 15'h7abc;
        i_reqSize   = 2'd3;
        i_wdata     = 32'hdead_beef;
    endtask

    initial begin
        rst = 1'b0; i_v = 1'b1; i_rd = 1'b0; i_wr = 1'b0; i_cachable = 1'b1;
        i_phys_addr = '0; i_reqSize = '0; i_spill = 1'b0; i_wdata = '0;
        i_stall = 1'b1; i_flush = 1'b0; dc_ready = 1'b0; dc_rdata = '0;
        #2;
        chk("rst_dc_req", dc_req, 0);
        chk("rst_o_v", o_v, 0);
        chk("rst_o_stall", o_stall, 0);
        chk("rst_o_rdata", o_rdata, 0);
        chk("rst_fault", o_align_fault, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("pass_o_v", o_v, 1);
        chk("pass_o_stall", o_stall, 1);
        chk("pass_dc_req", dc_req, 0);
        i_v = 1'b0; i_stall = 1'b0;

        // Non-spill 4B load, zero wait
        tick(); present(1, 0, 15'h0100, 2, 0, 1, 0); dc_ready = 1; dc_rdata = 32'h4433_2211;
        #1; chk("acc_o_stall", o_stall, 1); chk("acc_dc_req", dc_req, 0);
        tick(); clear_op(); #1;
        chk("c1_req", dc_req, 1); chk("c1_addr", dc_addr, 15'h0100); chk("c1_size", dc_size, 2);
        chk("c1_we", dc_we, 0); chk("c1_uc", dc_uc, 0); chk("c1_o_v", o_v, 0);
        tick(); #1;
        chk("c2_o_v", o_v, 1); chk("c2_rdata", o_rdata, 32'h4433_2211);
        chk("c2_req", dc_req, 0); chk("c2_stall", o_stall, 0);
        tick(); #1; chk("c3_o_v", o_v, 0);

        // Uncached 1B load, DONE held by i_stall
        tick(); present(1, 0, 15'h0203, 0, 0, 0, 0); dc_rdata = 32'haabb_ccdd;
        tick(); clear_op(); #1;
        chk("uc_dc_uc", dc_uc, 1); chk("uc_size", dc_size, 0); chk("uc_addr", dc_addr, 15'h0203);
        tick(); i_stall = 1; #1;
        chk("hold_o_v", o_v, 1); chk("hold_stall", o_stall, 1); chk("uc_rdata", o_rdata, 32'hdd);
        tick(); #1;
        chk("hold2_o_v", o_v, 1); chk("hold2_rdata", o_rdata, 32'hdd);
        i_stall = 0;
        tick(); #1; chk("after_hold_o_v", o_v, 0);

        // 2B store
        tick(); present(0, 1, 15'h0010, 1, 0, 1, 32'hcafe_babe);
        tick(); clear_op(); #1;
        chk("st_we", dc_we, 1); chk("st_wdata", dc_wdata, 32'hbabe); chk("st_req", dc_req, 1);
        tick(); #1; chk("st_done_o_v", o_v, 1);

        // Five wait states in ACC1
        tick(); present(1, 0, 15'h0444, 2, 0, 1, 0); dc_ready = 0;
        tick(); clear_op();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("wait_req", dc_req, 1); chk("wait_addr", dc_addr, 15'h0444);
            chk("wait_size", dc_size, 2); chk("wait_stall", o_stall, 1); chk("wait_o_v", o_v, 0);
            tick();
        end
        dc_ready = 1; dc_rdata = 32'h1234_5678;
        #1; chk("wait_end_req", dc_req, 1);
        tick(); #1; chk("wait_o_v_done", o_v, 1); chk("wait_rdata", o_rdata, 32'h1234_5678);

        // Flush in ACC1 while cache not ready -> DRAIN
        tick(); present(1, 0, 15'h0500, 2, 0, 1, 0); dc_ready = 0;
        tick(); clear_op(); i_flush = 1; #1;
        chk("fl_req", dc_req, 1); chk("fl_o_v", o_v, 0);
        tick(); i_flush = 0; #1;
        chk("dr_req", dc_req, 1); chk("dr_addr", dc_addr, 15'h0500);
        chk("dr_stall", o_stall, 1); chk("dr_o_v", o_v, 0);
        tick(); #1; chk("dr2_req", dc_req, 1); chk("dr2_o_v", o_v, 0);
        dc_ready = 1;
        tick(); #1;
        chk("drn_req", dc_req, 0); chk("drn_o_v", o_v, 0); chk("drn_stall", o_stall, 0);

        // Flush coincident with the transfer
        tick(); present(1, 0, 15'h0600, 2, 0, 1, 0);
        tick(); clear_op(); i_flush = 1; #1; chk("fx_req", dc_req, 1);
        tick(); i_flush = 0; #1;
        chk("fx_o_v", o_v, 0); chk("fx_req_after", dc_req, 0); chk("fx_stall", o_stall, 0);

        // Flush in DONE while stalled
        tick(); present(1, 0, 15'h0700, 2, 0, 1, 0); dc_rdata = 32'h0bad_f00d;
        tick(); clear_op();
        tick(); i_flush = 1; i_stall = 1; #1; chk("fd_o_v", o_v, 1);
        tick(); i_flush = 0; i_stall = 0; #1;
        chk("fd_next_o_v", o_v, 0); chk("fd_req", dc_req, 0);

        // Flush in IDLE kills the op
        tick(); present(1, 0, 15'h0800, 2, 0, 1, 0); i_flush = 1; #1;
        chk("fi_stall", o_stall, 0); chk("fi_o_v", o_v, 0);
        tick(); clear_op(); i_flush = 0; #1;
        chk("fi_req", dc_req, 0); chk("fi_o_stall", o_stall, 0);

`ifdef MEM_SPLIT_EN
        // Spill 4B load at 0x010E
        tick(); present(1, 0, 15'h010e, 2, 1, 1, 0); dc_ready = 1; dc_rdata = 32'h0000_bbaa;
        tick(); clear_op(); #1;
        chk("a1_req", dc_req, 1); chk("a1_addr", dc_addr, 15'h010e); chk("a1_size", dc_size, 1);
        tick(); dc_rdata = 32'h0000_ddcc; #1;
        chk("a2_req", dc_req, 1); chk("a2_addr", dc_addr, 15'h0110); chk("a2_size", dc_size, 1);
        chk("a2_stall", o_stall, 1);
        tick(); #1;
        chk("sp_o_v", o_v, 1); chk("sp_rdata", o_rdata, 32'hddcc_bbaa);
        chk("sp_fault", o_align_fault, 0);

        // Spill 2B store wrapping the address space
        tick(); present(0, 1, 15'h7fff, 1, 1, 1, 32'h0000_2211);
        tick(); clear_op(); #1;
        chk("s1_addr", dc_addr, 15'h7fff); chk("s1_size", dc_size, 0); chk("s1_data", dc_wdata, 32'h11);
        tick(); #1;
        chk("s2_addr", dc_addr, 15'h0000); chk("s2_size", dc_size, 0); chk("s2_data", dc_wdata, 32'h22);
        chk("s2_we", dc_we, 1);
        tick(); #1; chk("s_done_o_v", o_v, 1);

        // Reset pulsed mid-ACC2
        tick(); present(1, 0, 15'h01fd, 2, 1, 1, 0); dc_ready = 1;
        tick(); clear_op();
        tick(); dc_ready = 0; #1; chk("ra_req", dc_req, 1);
`else
        // Spill without split support faults immediately
        tick(); present(1, 0, 15'h010e, 2, 1, 1, 0); dc_ready = 1; #1;
        chk("sp_accept_req", dc_req, 0);
        tick(); clear_op(); #1;
        chk("sp_req", dc_req, 0); chk("sp_o_v", o_v, 1);
        chk("sp_fault", o_align_fault, 1); chk("sp_rdata", o_rdata, 0);
        tick(); #1; chk("sp_fault_clr", o_align_fault, 0); chk("sp_idle_o_v", o_v, 0);

        // Reset pulsed mid-ACC1
        tick(); present(1, 0, 15'h0300, 2, 0, 1, 0); dc_ready = 0;
        tick(); clear_op(); #1; chk("ra_req", dc_req, 1);
`endif
        #1 rst = 0;
        #1;
        chk("ra_rst_req", dc_req, 0); chk("ra_rst_o_v", o_v, 0); chk("ra_rst_stall", o_stall, 0);
        #1 rst = 1;

        // Clean op after reset
        tick(); present(1, 0, 15'h0020, 2, 0, 1, 0); dc_ready = 1; dc_rdata = 32'h8765_4321; #1;
        chk("post_stall", o_stall, 1);
        tick(); clear_op(); #1;
        chk("post_req", dc_req, 1); chk("post_addr", dc_addr, 15'h0020);
        tick(); #1;
        chk("post_o_v", o_v, 1); chk("post_rdata", o_rdata, 32'h8765_4321);
        tick(); #1; chk("post_idle_o_v", o_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter SPLIT_EN_DEFAULT, default 1, meaning reset value of the split-enable bit (effective only with MEM_SPLIT_EN).
REQ-002 SHALL have ports, with clock and reset first: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-003 SHALL have latch-side inputs, all from the upstream MP latch: i_v 1 valid; i_rd 1 load; i_wr 1 store; i_cachable 1; i_phys_addr 15 byte address; i_reqSize 2 (0=1B, 1=2B, 2=4B); i_spill 1 line-crossing access; i_wdata 32 store data.
REQ-004 SHALL have i_stall in 1, the downstream stall, and i_flush in 1, the pipeline invalidate.
REQ-005 SHALL have cache-port outputs: dc_req 1; dc_we 1; dc_uc 1 (uncached); dc_addr 15; dc_size 2; dc_wdata 32.
REQ-006 SHALL have cache-port inputs: dc_ready 1; dc_rdata 32 (little-endian, requested bytes in the low lanes).
REQ-007 SHALL have stage outputs: o_stall 1 to the MP latch; o_v 1; o_rdata 32; o_align_fault 1.

Function
REQ-008 SHALL treat a cycle with dc_req=1 and dc_ready=1 as a transfer; dc_addr, dc_we, dc_size, dc_wdata and dc_uc SHALL stay stable while dc_req=1 and dc_ready=0.
REQ-009 SHALL implement FSM states IDLE, ACC1, ACC2, DONE and DRAIN.
REQ-010 In IDLE with i_v=1 and i_rd=0 and i_wr=0, SHALL pass the op through: o_v=i_v and o_stall=i_stall.
REQ-011 In IDLE with i_v=1 and i_rd|i_wr, SHALL capture all latch fields, assert o_stall=1 and move to ACC1.
REQ-012 In ACC1, SHALL drive dc_req=1 and dc_addr=phys_addr.
  - Non-spill: dc_size=reqSize.
  - Spill: dc_size encodes n1 = 16 - phys_addr[3:0] bytes.
  - On transfer: go to ACC2 if spill, else DONE.
REQ-013 In ACC2, SHALL drive dc_req=1 and dc_addr={phys_addr[14:4]+1, 4'h0}, with wrap-around from 0x7FF0 to 0x0000.
  - Size: the remaining (bytes(reqSize) - n1) bytes.
  - Stores send wdata >> (8*n1).
REQ-014 On the ACC1 transfer, SHALL store the first part in a 32-bit merge register.
  - For a spill load, o_rdata = first[8*n1-1:0] | (second << 8*n1).
  - Bytes above the access size SHALL be zeroed.
REQ-015 In DONE, SHALL drive o_v=1, o_rdata valid and o_stall=i_stall; move to IDLE when i_stall=0, else hold all outputs.
REQ-016 o_stall SHALL be 1 in ACC1, ACC2 and DRAIN.
REQ-017 Zero-wait latency SHALL be: non-spill, accept cycle + 1 + 1 (DONE) = 3 cycles; spill, 4 cycles.
REQ-018 i_flush in IDLE or DONE SHALL force IDLE with o_v=0 on the next cycle.
REQ-019 i_flush in ACC1 or ACC2 with dc_ready=0 SHALL go to DRAIN, which keeps dc_req asserted until the transfer, then goes to IDLE with no o_v.
REQ-020 i_flush coincident with a transfer SHALL go to IDLE directly.
REQ-021 dc_uc SHALL equal ~cachable; uncached accesses SHALL follow identical handshakes.

Reset
REQ-022 While rst=0, SHALL hold state IDLE and registers at 0, so dc_req=0, o_v=0, o_stall=0, o_rdata=0 and o_align_fault=0.
REQ-023 Reset asserted mid-access SHALL abandon the access immediately; the cache side is reset by the same rst.

Configuration
REQ-024 With macro MEM_SPLIT_EN defined, SHALL include the ACC2 state and merge logic per REQ-012 to REQ-014.
REQ-025 Without MEM_SPLIT_EN, a spill op SHALL issue no request and go to DONE with o_align_fault=1 and o_rdata=0.
REQ-026 o_align_fault SHALL otherwise be 0.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the reqSize encodings, and the LINE_BYTES=16 and ADDR_W=15 constants.
REQ-028 Byte-count and shift/merge logic SHALL live in one sub-module, mem_merge, which is combinational: inputs first, second, n1, size; output merged data.

Verification
REQ-029 Non-spill 4B load at 0x0100 with dc_ready tied 1 -> dc_req in cycle 1 only; o_v=1 with o_rdata=dc_rdata in cycle 2.
REQ-030 Spill 4B load at 0x010E; first returns 0x0000BBAA, second 0x0000DDCC -> ACC2 addr 0x0110 size 2B; o_rdata=0xDDCCBBAA.
REQ-031 Spill 2B store at 0x7FFF with wdata 0x00002211 -> ACC1 addr 0x7FFF 1B data 0x11; ACC2 addr 0x0000 1B data 0x22.
REQ-032 dc_ready held 0 for 5 cycles in ACC1 -> dc_addr/dc_size stable for all 5 cycles; o_stall=1 throughout.
REQ-033 i_flush in ACC1 with dc_ready=0, then ready 2 cycles later -> dc_req held until transfer; FSM to IDLE; o_v never 1.
REQ-034 rst=0 pulsed mid-ACC2 -> dc_req=0 and o_v=0 asynchronously; the next op starts cleanly from IDLE.
